mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the instruction-fetch (IF) requester and the
//  data-memory (DM) load/store requester of the pipelined RV32I core. Allows one outstanding
//  transaction at a time. Data port has priority, subject to an anti-starvation streak limit for IF.
//  Guards against a hung memory with a timeout and a sticky error flag.
//  Core stalls IF/MEM stages on !gnt / !rvalid.
// PARAMETERS
//  XLEN        32    address/data width (from riscv_pkg)
//  DM_MAX      4     max consecutive DM grants while IF is waiting; then IF wins once
//  TIMEOUT_CYC 64    cycles in WAIT without mem_rvalid_i before abort (>=2)
// PORTS
//  clk_i        in   1     system clock, rising edge
//  rst_i        in   1     synchronous active-high reset
//  if_req_i     in   1     IF read request; held until if_gnt_o
//  if_addr_i    in   XLEN  IF word address
//  if_gnt_o     out  1     IF request accepted this cycle
//  if_rvalid_o  out  1     IF read data valid (1-cycle pulse)
//  if_rdata_o   out  XLEN  IF read data
//  dm_req_i     in   1     DM request; held until dm_gnt_o
//  dm_we_i      in   1     DM write (1) / read (0)
//  dm_addr_i    in   XLEN  DM address
//  dm_wdata_i   in   XLEN  DM write data
//  dm_be_i      in   4     DM byte enables
//  dm_gnt_o     out  1     DM request accepted this cycle
//  dm_rvalid_o  out  1     DM read data valid / write ack (1-cycle pulse)
//  dm_rdata_o   out  XLEN  DM read data (0 for write acks)
//  mem_req_o    out  1     memory command strobe (1-cycle pulse)
//  mem_we_o     out  1     memory write enable
//  mem_addr_o   out  XLEN  memory address
//  mem_wdata_o  out  XLEN  memory write data
//  mem_be_o     out  4     memory byte enables (4'hF for IF)
//  mem_rvalid_i in   1     memory response (read data or write ack), >=1 cycle after mem_req_o
//  mem_rdata_i  in   XLEN  memory read data
//  err_o        out  1     sticky timeout flag
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0, including err_o. Streak counter=0. Timeout counter=0.
//  - FSM:
//    - IDLE/RESP: arbitrate.
//    - Winner's gnt_o is combinational in cycle T. Request fields are latched at the end of T.
//    - Next state is ISSUE. With no request: IDLE->IDLE, RESP->IDLE.
//  - ISSUE (1 cycle): mem_req_o=1 with the latched we/addr/wdata/be; IF uses we=0, be=4'hF. Next state is WAIT.
//  - WAIT: the timeout counter increments each cycle.
//    - On mem_rvalid_i: capture rdata. Next state is RESP.
//    - If the count reaches TIMEOUT_CYC first: rdata=32'hDEAD_BEEF, err_o<=1. Next state is RESP.
//    - If mem_rvalid_i and the timeout occur in the same cycle, mem_rvalid_i wins and there is no error.
//  - RESP (1 cycle): owner's rvalid_o=1 with captured rdata (DM write ack: rdata=0). The other port's rvalid_o stays 0.
//  - Minimum latency, gnt to rvalid: 3 cycles with a 1-cycle memory. Back-to-back grants happen in RESP.
//  - Arbitration:
//    - Only one requester: grant it.
//    - Both requesting: grant DM, unless streak==DM_MAX, then grant IF.
//  - Streak counter:
//    - DM grant while if_req_i=1: streak+1, saturating at DM_MAX.
//    - IF grant: streak=0.
//    - DM grant with if_req_i=0: streak=0.
//  - gnt_o is never asserted in ISSUE/WAIT. At most one gnt_o is high per cycle.
//  - mem_rvalid_i outside WAIT (stray or late after timeout) is ignored.
//  - err_o stays high until rst_i. A timeout does not block later transactions.
//  - rst_i mid-transaction drops it: no rvalid_o is produced. Any later stray mem_rvalid_i is ignored.
//  - Outputs from registers except gnt_o. rdata_o holds its last value when rvalid_o=0.
// TESTING
//  - IF read @0x10, memory answers 1 cycle after mem_req_o with 0x00500093:
//    if_gnt_o T0, mem_req_o T1, if_rvalid_o T3, data 0x00500093.
//  - if_req_i and dm_req_i together (DM read @0x100) -> dm_gnt_o first.
//    if_gnt_o in DM's RESP cycle. mem_req_o addr order 0x100 then the IF address.
//  - DM write 0xCAFEBABE be=4'b0011 @0x200 -> mem_we_o=1, mem_be_o=4'b0011, wdata passed through.
//    dm_rvalid_o pulse with dm_rdata_o=0.
//  - DM_MAX=4, both requesting continuously -> grant sequence DM,DM,DM,DM,IF,DM... Streak resets after IF.
//  - Memory never answers, TIMEOUT_CYC=8 -> RESP 8 cycles after WAIT entry: rvalid with 0xDEADBEEF, err_o=1 held.
//    A later stray mem_rvalid_i in IDLE gives no rvalid.
//  - rst_i asserted in WAIT -> next cycle IDLE, all outputs 0, err_o=0.
//    mem_rvalid_i 2 cycles later gives no rvalid_o.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Ports: IF/DM request channels (*_req/gnt/rvalid/rdata), memory command side
// (mem_*), sticky timeout flag err_o. Sync active-high reset on rst_i.
module mem_port_arbiter #(
  parameter int XLEN        = 32,
  parameter int DM_MAX      = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [XLEN-1:0] dm_addr_i,
  input  logic [XLEN-1:0] dm_wdata_i,
  input  logic [3:0]      dm_be_i,
  output logic            dm_gnt_o,
  output logic            dm_rvalid_o,
  output logic [XLEN-1:0] dm_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_be_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            err_o
);

  localparam int SW = $clog2(DM_MAX + 1);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [XLEN-1:0] TO_DATA = XLEN'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [SW-1:0]   streak;
  logic [CW-1:0]   tcnt;
  logic            own_dm;
  logic            arb;
  logic            give_if;
  logic            give_dm;
  logic            hit;
  logic            tmo;
  logic [XLEN-1:0] rsp;

  always_comb begin
    state_n = state;
    arb     = (state == IDLE) || (state == RESP);
    // IF only beats a competing DM request once the DM streak is full
    give_if = arb && if_req_i
            && (!dm_req_i || (streak == SW'(DM_MAX)));
    give_dm = arb && dm_req_i && !give_if;
    hit     = (state == WAIT) && mem_rvalid_i;
    // a response arriving on the last count still wins over the abort
    tmo     = (state == WAIT) && !mem_rvalid_i
            && (tcnt == CW'(TIMEOUT_CYC - 1));
    rsp     = hit ? mem_rdata_i : TO_DATA;
    if_gnt_o = give_if;
    dm_gnt_o = give_dm;
    unique case (state)
      IDLE, RESP: state_n = (give_if || give_dm) ? ISSUE : IDLE;
      ISSUE:      state_n = WAIT;
      WAIT:       if (hit || tmo) state_n = RESP;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      streak      <= '0;
      tcnt        <= '0;
      own_dm      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= 4'h0;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      dm_rvalid_o <= 1'b0;
      dm_rdata_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_n;
      mem_req_o   <= 1'b0;
      if_rvalid_o <= 1'b0;
      dm_rvalid_o <= 1'b0;

      // mem_* registers double as the latched command for the transaction
      if (give_if || give_dm) begin
        own_dm      <= give_dm;
        mem_req_o   <= 1'b1;
        mem_we_o    <= give_dm && dm_we_i;
        mem_addr_o  <= give_dm ? dm_addr_i : if_addr_i;
        mem_wdata_o <= give_dm ? dm_wdata_i : '0;
        mem_be_o    <= give_dm ? dm_be_i : 4'hF;
      end

      if (give_if) begin
        streak <= '0;
      end else if (give_dm) begin
        if (!if_req_i)
          streak <= '0;
        else if (streak != SW'(DM_MAX))
          streak <= streak + 1'b1;
      end

      if (state == ISSUE)
        tcnt <= '0;
      else if (state == WAIT)
        tcnt <= tcnt + 1'b1;

      if (hit || tmo) begin
        if (tmo)
          err_o <= 1'b1;
        if (own_dm) begin
          dm_rvalid_o <= 1'b1;
          dm_rdata_o  <= (mem_we_o && hit) ? '0 : rsp;
        end else begin
          if_rvalid_o <= 1'b1;
          if_rdata_o  <= rsp;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard
// and a small memory model (1-cycle latency, can be muted).
module tb_mem_port_arbiter;

  typedef struct {
    bit          dm;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dreq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  mem_port_arbiter #(
    .XLEN(32),
    .DM_MAX(4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .if_req_i(if_req),
    .if_addr_i(if_addr),
    .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid),
    .if_rdata_o(if_rdata),
    .dm_req_i(dm_req),
    .dm_we_i(dm_we),
    .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata),
    .dm_be_i(dm_be),
    .dm_gnt_o(dm_gnt),
    .dm_rvalid_o(dm_rvalid),
    .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be),
    .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata),
    .err_o(err)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [31:0] if_q[$];
  dreq_t       dm_q[$];
  bit          glog[$];
  dreq_t       ml[$];
  int          mcyc[$];
  int          last_if_gnt;
  int          last_if_rv;
  int          last_dm_rv;
  logic [31:0] mem [0:255];
  bit          mute = 1'b0;
  bit          stray = 1'b0;
  int          pend = 0;
  logic [31:0] pend_data;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(logic [31:0] a);
    logic [7:0] i;
    i = a[9:2];
    return mem[i];
  endfunction

  task automatic wr(logic [31:0] a, logic [31:0] d,
                    logic [3:0] be);
    logic [7:0]  i;
    logic [31:0] m;
    i = a[9:2];
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    mem[i] = (mem[i] & ~m) | (d & m);
  endtask

  task automatic tick();
    logic [31:0] a;
    dreq_t       d;
    exp_t        e;
    #1;
    chk("gnt_excl", 32'(if_gnt & dm_gnt), 0);
    if (if_gnt) begin
      chk("if_gnt_req", 32'(if_q.size() != 0), 1);
      if (if_q.size() != 0) begin
        a = if_q.pop_front();
        sb.push_back('{1'b0, mute ? 32'hDEAD_BEEF : rd(a)});
        glog.push_back(1'b0);
        last_if_gnt = cyc;
      end
    end
    if (dm_gnt) begin
      chk("dm_gnt_req", 32'(dm_q.size() != 0), 1);
      if (dm_q.size() != 0) begin
        d = dm_q.pop_front();
        sb.push_back('{1'b1, mute ? 32'hDEAD_BEEF :
                       (d.we ? 32'h0 : rd(d.addr))});
        glog.push_back(1'b1);
      end
    end
    @(negedge clk);
    cyc++;
    if (if_rvalid || dm_rvalid) begin
      chk("rv_excl", 32'(if_rvalid & dm_rvalid), 0);
      chk("rv_pending", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rv_port", 32'(dm_rvalid), 32'(e.dm));
        chk("rv_data", dm_rvalid ? dm_rdata : if_rdata, e.data);
      end
      if (if_rvalid) last_if_rv = cyc;
      if (dm_rvalid) last_dm_rv = cyc;
    end
    mem_rvalid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_data;
      end
    end
    if (stray) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0BAD_0BAD;
      stray      = 1'b0;
    end
    if (mem_req) begin
      ml.push_back('{mem_we, mem_addr, mem_wdata, mem_be});
      mcyc.push_back(cyc);
      if (!mute) begin
        if (mem_we) wr(mem_addr, mem_wdata, mem_be);
        pend      = 1;
        pend_data = mem_we ? 32'h0 : rd(mem_addr);
      end
    end
    if_req  = (if_q.size() != 0);
    if_addr = if_req ? if_q[0] : 32'h0;
    dm_req  = (dm_q.size() != 0);
    if (dm_req) begin
      dm_we    = dm_q[0].we;
      dm_addr  = dm_q[0].addr;
      dm_wdata = dm_q[0].wdata;
      dm_be    = dm_q[0].be;
    end else begin
      dm_we    = 1'b0;
      dm_addr  = 32'h0;
      dm_wdata = 32'h0;
      dm_be    = 4'h0;
    end
  endtask

  task automatic drain(int lim);
    int n = 0;
    while ((sb.size() != 0 || if_q.size() != 0 ||
            dm_q.size() != 0) && n < lim) begin
      tick();
      n++;
    end
    chk("drain_budget", 32'(n < lim), 1);
    sb.delete();
    tick();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"},
        32'({if_gnt, dm_gnt, if_rvalid, dm_rvalid,
             mem_req, mem_we, err, mem_be}), 0);
    chk({tag, "_dat"},
        if_rdata | dm_rdata | mem_addr | mem_wdata, 0);
  endtask

  bit exp_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 32'h1234_0000 | i;
    mem[4]     = 32'h0050_0093;
    rst        = 1'b1;
    if_req     = 1'b0;
    if_addr    = 32'h0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = 32'h0;
    dm_wdata   = 32'h0;
    dm_be      = 4'h0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // single IF read, minimum latency
    if_q.push_back(32'h10);
    drain(20);
    chk("if_lat", 32'(last_if_rv - last_if_gnt), 3);
    chk("if_req_lat", 32'(mcyc[$] - last_if_gnt), 1);
    chk("if_rdata", if_rdata, 32'h0050_0093);
    chk("if_mem_we", 32'(ml[$].we), 0);
    chk("if_mem_be", 32'(ml[$].be), 32'hF);
    chk("if_mem_addr", ml[$].addr, 32'h10);

    // simultaneous requests: DM first, IF in DM's RESP
    ml.delete();
    glog.delete();
    if_q.push_back(32'h20);
    dm_q.push_back('{1'b0, 32'h100, 32'h0, 4'hF});
    drain(30);
    chk("pri_cnt", 32'(glog.size()), 2);
    chk("pri_first", 32'(glog[0]), 1);
    chk("pri_second", 32'(glog[1]), 0);
    chk("pri_addr0", ml[0].addr, 32'h100);
    chk("pri_addr1", ml[1].addr, 32'h20);
    chk("pri_b2b", 32'(last_if_gnt), 32'(last_dm_rv));

    // partial write then read-back
    ml.delete();
    dm_q.push_back('{1'b1, 32'h200, 32'hCAFE_BABE, 4'b0011});
    dm_q.push_back('{1'b0, 32'h200, 32'h0, 4'hF});
    drain(30);
    chk("wr_we", 32'(ml[0].we), 1);
    chk("wr_be", 32'(ml[0].be), 32'h3);
    chk("wr_wdata", ml[0].wdata, 32'hCAFE_BABE);
    chk("wr_addr", ml[0].addr, 32'h200);
    chk("rd_merge", dm_rdata, 32'h1234_BABE);

    // anti-starvation streak
    glog.delete();
    for (int i = 0; i < 2; i++)
      if_q.push_back(32'h40 + 32'(4 * i));
    for (int i = 0; i < 8; i++)
      dm_q.push_back('{1'b0, 32'h300 + 32'(4 * i),
                       32'h0, 4'hF});
    drain(200);
    chk("streak_cnt", 32'(glog.size()), 10);
    for (int i = 0; i < 10; i++)
      if (i < glog.size())
        chk($sformatf("streak_%0d", i),
            32'(glog[i]), 32'(exp_seq[i]));

    // timeout, stray response, recovery
    mute = 1'b1;
    ml.delete();
    mcyc.delete();
    if_q.push_back(32'h30);
    drain(60);
    chk("to_lat", 32'(last_if_rv - mcyc[0]), 9);
    chk("to_err", 32'(err), 1);
    chk("to_rdata", if_rdata, 32'hDEAD_BEEF);
    stray = 1'b1;
    repeat (4) tick();
    chk("stray_err", 32'(err), 1);
    chk("stray_rdata", if_rdata, 32'hDEAD_BEEF);
    mute = 1'b0;
    if_q.push_back(32'h10);
    drain(20);
    chk("rec_rdata", if_rdata, 32'h0050_0093);
    chk("rec_err", 32'(err), 1);

    // reset in WAIT drops the transaction
    mute = 1'b1;
    ml.delete();
    if_q.push_back(32'h14);
    for (int i = 0; i < 10 && ml.size() == 0; i++)
      tick();
    chk("mr_issue", 32'(ml.size()), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrst");
    sb.delete();
    tick();
    stray = 1'b1;
    repeat (5) tick();
    chk("midrst_rv", 32'({if_rvalid, dm_rvalid}), 0);
    chk("midrst_err", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
